// File: rtl/alu_muldiv_ctrl_if.sv
// Execute-stage bus between the core and alu_muldiv_ctrl: decode fields,
// operands and handshake in; ALU opcode, mul/div result and stall out.
interface alu_muldiv_ctrl_if #(
  parameter int unsigned XLEN = 32
);
  logic [1:0]      aluop;
  logic [2:0]      funct3;
  logic            funct7_5;
  logic            funct7_0;
  logic            op5;
  logic            ex_valid;
  logic            kill;
  logic [XLEN-1:0] opa;
  logic [XLEN-1:0] opb;
  logic [4:0]      aluopcode;
  logic            md_sel;
  logic [XLEN-1:0] md_result;
  logic            stall;

  modport master (
    output aluop, funct3, funct7_5, funct7_0, op5, ex_valid, kill, opa, opb,
    input  aluopcode, md_sel, md_result, stall
  );

  modport slave (
    input  aluop, funct3, funct7_5, funct7_0, op5, ex_valid, kill, opa, opb,
    output aluopcode, md_sel, md_result, stall
  );
endinterface

// File: rtl/alu_muldiv_ctrl.sv
// ALU control decoder with an optional iterative multiply/divide unit.
// Define ALU_MULDIV_CTRL_MULDIV_EN to build the bit-serial mul/div FSM;
// without it M-op MUL maps to a single-cycle ALU opcode and the other
// M-ops decode as ADD, with stall/md_sel/md_result tied low.
module alu_muldiv_ctrl #(
  parameter int unsigned XLEN = 32
) (
  input logic               clk,
  input logic               rst_n,
  alu_muldiv_ctrl_if.slave  bus
);

  logic [4:0] op_sel;

  // ALU operation decode from aluop/funct fields
  always_comb begin
    op_sel = 5'b00000;
    case (bus.aluop)
      2'b00: op_sel = 5'b00000;
      2'b01: op_sel = 5'b10000;
      2'b10: begin
        if (bus.funct7_0) begin
`ifdef ALU_MULDIV_CTRL_MULDIV_EN
          op_sel = 5'b00000;
`else
          op_sel = (bus.funct3 == 3'b000) ? 5'b01001 : 5'b00000;
`endif
        end else begin
          case (bus.funct3)
            3'b000:  op_sel = bus.funct7_5 ? 5'b10000 : 5'b00000;
            3'b101:  op_sel = bus.funct7_5 ? 5'b10101 : 5'b00101;
            default: op_sel = {2'b00, bus.funct3};
          endcase
        end
      end
      default: op_sel = (bus.funct3 == 3'b101 && bus.funct7_5) ? 5'b10101
                                                               : {2'b00, bus.funct3};
    endcase
  end

  assign bus.aluopcode = op_sel;

`ifdef ALU_MULDIV_CTRL_MULDIV_EN
  localparam int unsigned CW = $clog2(XLEN) + 1;

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t          state;
  logic [CW-1:0]   cnt;
  logic [XLEN-1:0] a_lat;
  logic [XLEN-1:0] b_lat;
  logic [2:0]      f3_lat;
  logic [XLEN-1:0] acc;      // product high half, or partial remainder
  logic [XLEN-1:0] q;        // multiplier / product low half, or quotient
  logic [XLEN-1:0] result;
  logic            md_sel_r;

  logic            md_req;
  logic            is_div;
  logic            a_neg;
  logic            b_neg;
  logic [XLEN-1:0] b_mag;
  logic [XLEN:0]   sum;
  logic [XLEN:0]   shifted;
  logic [XLEN-1:0] acc_n;
  logic [XLEN-1:0] q_n;
  logic [XLEN-1:0] res_n;

  assign md_req = bus.ex_valid & (bus.aluop == 2'b10) & bus.funct7_0 & bus.op5;
  assign is_div = f3_lat[2];
  assign a_neg  = f3_lat[2] & ~f3_lat[0] & a_lat[XLEN-1];
  assign b_neg  = f3_lat[2] & ~f3_lat[0] & b_lat[XLEN-1];
  assign b_mag  = b_neg ? -b_lat : b_lat;

  // One iteration: shift-add multiply step or restoring divide step
  always_comb begin
    sum     = '0;
    shifted = '0;
    acc_n   = acc;
    q_n     = q;
    if (is_div) begin
      shifted = {acc, q[XLEN-1]};
      if (shifted >= {1'b0, b_mag}) begin
        // difference is below the divisor, so it fits in XLEN bits
        acc_n = shifted[XLEN-1:0] - b_mag;
        q_n   = {q[XLEN-2:0], 1'b1};
      end else begin
        acc_n = shifted[XLEN-1:0];
        q_n   = {q[XLEN-2:0], 1'b0};
      end
    end else begin
      sum   = {1'b0, acc} + (q[0] ? {1'b0, b_lat} : '0);
      acc_n = sum[XLEN:1];
      q_n   = {sum[0], q[XLEN-1:1]};
    end
  end

  // Final result selection with sign fix-up and divide-by-zero override
  always_comb begin
    case (f3_lat)
      3'b011:         res_n = acc_n;
      3'b100, 3'b101: res_n = (b_lat == '0) ? '1 : ((a_neg ^ b_neg) ? -q_n : q_n);
      3'b110, 3'b111: res_n = (b_lat == '0) ? a_lat : (a_neg ? -acc_n : acc_n);
      default:        res_n = q_n;
    endcase
  end

  // Control FSM with iteration datapath and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      cnt      <= '0;
      a_lat    <= '0;
      b_lat    <= '0;
      f3_lat   <= '0;
      acc      <= '0;
      q        <= '0;
      result   <= '0;
      md_sel_r <= 1'b0;
    end else begin
      md_sel_r <= 1'b0;
      if (bus.kill) begin
        state <= IDLE;
      end else begin
        case (state)
          IDLE: begin
            if (md_req) begin
              state  <= CALC;
              cnt    <= '0;
              a_lat  <= bus.opa;
              b_lat  <= bus.opb;
              f3_lat <= bus.funct3;
              acc    <= '0;
              q      <= (bus.funct3[2] & ~bus.funct3[0] & bus.opa[XLEN-1]) ? -bus.opa
                                                                          : bus.opa;
            end
          end
          CALC: begin
            acc <= acc_n;
            q   <= q_n;
            cnt <= cnt + 1'b1;
            if (cnt == CW'(XLEN - 1)) begin
              state    <= DONE;
              result   <= res_n;
              md_sel_r <= 1'b1;
            end
          end
          DONE:    state <= IDLE;
          default: state <= IDLE;
        endcase
      end
    end
  end

  assign bus.stall     = md_req & (state != DONE);
  assign bus.md_sel    = md_sel_r;
  assign bus.md_result = result;
`else
  logic unused_inputs;
  assign unused_inputs = ^{clk, rst_n, bus.ex_valid, bus.kill, bus.opa, bus.opb, bus.op5};

  assign bus.stall     = 1'b0;
  assign bus.md_sel    = 1'b0;
  assign bus.md_result = '0;
`endif

endmodule
